discharge_pulse_fsm: RTL

Discharge-cycle sequencer for the EDM pulse generator. It owns the state word and the wait-for-breakdown timer that the breakdown detector consumes, and it reacts to the detector's is_breakdown flag. It drives the buck/resistor MOSFET gates through wait, discharge and deionisation phases, in single-shot or continuous mode, as selected by the waveform word.

---
 rtl/discharge_pulse_fsm.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/discharge_pulse_fsm.sv
// EDM discharge-cycle sequencer: wait-for-breakdown, discharge and deionisation
// phases with registered MOSFET gate outputs that always match the presented state.
module discharge_pulse_fsm #(
  parameter logic [31:0] RISE_CYCLES     = 32'd400,
  parameter logic [31:0] WAIT_TIMEOUT    = 32'd100000,
  parameter logic [15:0] INTERLEAVE_HALF = 16'd50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_en,
  input  logic [15:0] waveform,
  input  logic [15:0] ton_cycles,
  input  logic [15:0] toff_cycles,
  input  logic        is_breakdown,
  output logic [7:0]  current_state,
  output logic [31:0] timer_wait_breakdown,
  output logic [1:0]  buck_gate,
  output logic        res_gate,
  output logic        pulse_done,
  output logic        open_circuit
);

  typedef enum logic [7:0] {
    ST_IDLE     = 8'b0100_0000,
    ST_WAIT     = 8'b0000_0001,
    ST_BUCK     = 8'b0000_0010,
    ST_RES      = 8'b0000_0100,
    ST_DEION    = 8'b1000_0000,
    ST_DEION_SB = 8'b0000_0000
  } state_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] at_least_one(input logic [15:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

  state_t      r_state, w_state_n;
  logic [31:0] r_timer, w_timer_n;
  logic [15:0] r_cnt, w_cnt_n;
  logic [15:0] r_ph, w_ph_n;
  logic        r_leg, w_leg_n;
  logic [2:0]  r_wave, w_wave_n;   // {buck, continuous, open_loop}
  logic [15:0] r_ton, w_ton_n;
  logic [15:0] r_toff, w_toff_n;
  logic        r_abort, w_abort_n;
  logic        r_op_d;
  logic [1:0]  r_buck, w_buck_n;
  logic        r_res, w_res_n;
  logic        r_done, w_done_n;
  logic        r_oc, w_oc_n;
  logic        w_go_wait, w_go_dis, w_go_dei;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_timer <= 32'd0;
      r_cnt   <= 16'd0;
      r_ph    <= 16'd0;
      r_leg   <= 1'b0;
      r_wave  <= 3'd0;
      r_ton   <= 16'd0;
      r_toff  <= 16'd0;
      r_abort <= 1'b0;
      r_op_d  <= 1'b0;
      r_buck  <= 2'b00;
      r_res   <= 1'b0;
      r_done  <= 1'b0;
      r_oc    <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_timer <= w_timer_n;
      r_cnt   <= w_cnt_n;
      r_ph    <= w_ph_n;
      r_leg   <= w_leg_n;
      r_wave  <= w_wave_n;
      r_ton   <= w_ton_n;
      r_toff  <= w_toff_n;
      r_abort <= w_abort_n;
      r_op_d  <= op_en;
      r_buck  <= w_buck_n;
      r_res   <= w_res_n;
      r_done  <= w_done_n;
      r_oc    <= w_oc_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_timer_n = 32'd0;
    w_cnt_n   = r_cnt;
    w_ph_n    = r_ph;
    w_leg_n   = r_leg;
    w_wave_n  = r_wave;
    w_ton_n   = r_ton;
    w_toff_n  = r_toff;
    w_abort_n = r_abort;
    w_oc_n    = 1'b0;
    w_go_wait = 1'b0;
    w_go_dis  = 1'b0;
    w_go_dei  = 1'b0;
    w_buck_n  = 2'b00;
    w_res_n   = 1'b0;
    w_done_n  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (op_en && !r_op_d) w_go_wait = 1'b1;
      end
      ST_WAIT: begin
        if (!op_en) begin
          w_go_dei  = 1'b1;
          w_abort_n = 1'b1;
        end else if (!r_wave[0]) begin
          // Breakdown outranks a coincident timeout.
          if (is_breakdown) begin
            w_go_dis = 1'b1;
          end else if (r_timer >= WAIT_TIMEOUT - 32'd1) begin
            w_go_dei = 1'b1;
            w_oc_n   = 1'b1;
          end else begin
            w_timer_n = sat_inc32(r_timer);
          end
        end else if (r_timer == RISE_CYCLES - 32'd1) begin
          w_go_dis = 1'b1;
        end else begin
          w_timer_n = sat_inc32(r_timer);
        end
      end
      ST_BUCK, ST_RES: begin
        if (!op_en) begin
          w_go_dei  = 1'b1;
          w_abort_n = 1'b1;
        end else if (r_cnt == r_ton - 16'd1) begin
          w_go_dei = 1'b1;
        end else begin
          w_cnt_n = r_cnt + 16'd1;
          if (r_ph == INTERLEAVE_HALF - 16'd1) begin
            w_ph_n  = 16'd0;
            w_leg_n = ~r_leg;
          end else begin
            w_ph_n = r_ph + 16'd1;
          end
        end
      end
      ST_DEION, ST_DEION_SB: begin
        if (!op_en) w_abort_n = 1'b1;
        // An op_en drop anywhere in the pulse forbids a continuous re-fire.
        if (r_cnt == r_toff - 16'd1) begin
          if (r_wave[1] && op_en && !r_abort) w_go_wait = 1'b1;
          else                                w_state_n = ST_IDLE;
        end else begin
          w_cnt_n = r_cnt + 16'd1;
        end
      end
      default: w_state_n = ST_IDLE;
    endcase

    if (w_go_wait) begin
      w_state_n = ST_WAIT;
      w_timer_n = 32'd0;
      w_wave_n  = waveform[15:13];
      w_ton_n   = at_least_one(ton_cycles);
      w_toff_n  = at_least_one(toff_cycles);
      w_abort_n = 1'b0;
    end
    if (w_go_dis) begin
      w_state_n = r_wave[2] ? ST_BUCK : ST_RES;
      w_cnt_n   = 16'd0;
      w_ph_n    = 16'd0;
      w_leg_n   = 1'b0;
    end
    if (w_go_dei) begin
      w_state_n = r_wave[1] ? ST_DEION : ST_DEION_SB;
      w_cnt_n   = 16'd0;
    end

    // Gates are derived from the next state so they register together with it.
    case (w_state_n)
      ST_WAIT: begin
        if (w_wave_n[2]) w_buck_n = 2'b11;
        else             w_res_n  = 1'b1;
      end
      ST_BUCK:               w_buck_n = w_leg_n ? 2'b10 : 2'b01;
      ST_RES:                w_res_n  = 1'b1;
      ST_DEION, ST_DEION_SB: w_done_n = (w_cnt_n == w_toff_n - 16'd1);
      default: ;
    endcase
  end

  assign current_state        = r_state;
  assign timer_wait_breakdown = r_timer;
  assign buck_gate            = r_buck;
  assign res_gate             = r_res;
  assign pulse_done           = r_done;
  assign open_circuit         = r_oc;

endmodule
